// File: rtl/pred_pkg.sv
// Shared types for the prediction-check queue: entry layout, NOP encoding
// and the instruction-traits decoder used to classify the retiring entry.
package pred_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pred_pc;
    } pred_entry_t;

    // Trait bit positions produced by instr_traits()
    localparam int unsigned T_BR   = 0;
    localparam int unsigned T_JAL  = 1;
    localparam int unsigned T_JALR = 2;
    localparam int unsigned T_LD   = 3;
    localparam int unsigned T_ST   = 4;
    localparam int unsigned TRAIT_W = 5;

    typedef logic [TRAIT_W-1:0] traits_t;

    function automatic traits_t instr_traits(input logic [6:0] opcode);
        traits_t t;
        t = '0;
        case (opcode)
            7'b1100011: t[T_BR]   = 1'b1;
            7'b1101111: t[T_JAL]  = 1'b1;
            7'b1100111: t[T_JALR] = 1'b1;
            7'b0000011: t[T_LD]   = 1'b1;
            7'b0100011: t[T_ST]   = 1'b1;
            default:    t         = '0;
        endcase
        return t;
    endfunction

    function automatic logic has_trait(input logic [6:0] opcode, input int unsigned trait);
        traits_t t;
        t = instr_traits(opcode);
        return t[trait];
    endfunction

endpackage

// File: rtl/pred_check_queue_if.sv
// Fetch/execute/predictor-facing signal bundle of pred_check_queue.
// Stats outputs exist only when PRED_CHECK_STATS_EN is defined.
interface pred_check_queue_if;

    logic        en;
    logic        push;
    logic [31:0] push_pc;
    logic [31:0] push_instr;
    logic [31:0] push_pred_pc;
    logic        full;
    logic        resolve;
    logic [31:0] resolve_next_pc;
    logic        head_valid;
    logic [31:0] head_pc;
    logic [31:0] head_instr;
    logic        miss;
    logic [31:0] last_pc;
    logic [31:0] last_instr;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef PRED_CHECK_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_misses;

    modport master (
        output en, push, push_pc, push_instr, push_pred_pc, resolve, resolve_next_pc,
        input  full, head_valid, head_pc, head_instr, miss, last_pc, last_instr,
               redirect, redirect_pc, stat_branches, stat_misses
    );

    modport slave (
        input  en, push, push_pc, push_instr, push_pred_pc, resolve, resolve_next_pc,
        output full, head_valid, head_pc, head_instr, miss, last_pc, last_instr,
               redirect, redirect_pc, stat_branches, stat_misses
    );
`else
    modport master (
        output en, push, push_pc, push_instr, push_pred_pc, resolve, resolve_next_pc,
        input  full, head_valid, head_pc, head_instr, miss, last_pc, last_instr,
               redirect, redirect_pc
    );

    modport slave (
        input  en, push, push_pc, push_instr, push_pred_pc, resolve, resolve_next_pc,
        output full, head_valid, head_pc, head_instr, miss, last_pc, last_instr,
               redirect, redirect_pc
    );
`endif

endinterface

// File: rtl/pred_fifo.sv
// Circular in-order entry store with wrap-around pointers, occupancy count
// and a flush that empties the queue just past the entry being popped.
module pred_fifo
    import pred_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  pred_entry_t              wr_entry,
    input  logic                     rd,
    input  logic                     flush,
    output pred_entry_t              head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               wr_eff;
    pred_entry_t        mem_q [DEPTH];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wr_eff   = wr & ~(rd & flush);
        if (rd && flush) begin
            // Both pointers land just past the popped entry: queue empty
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            wr_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = '0;
        end else begin
            if (rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            case ({wr, rd})
                2'b10:   count_d = count_q + COUNT_W'(1);
                2'b01:   count_d = count_q - COUNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_eff) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pred_check_queue.sv
// Program-order queue between fetch and execute that checks each retiring
// prediction and drives predictor feedback plus redirect/flush on a miss.
// Optional branch/miss counters: define PRED_CHECK_STATS_EN.
module pred_check_queue
    import pred_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    pred_check_queue_if.slave bus
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    logic [COUNT_W-1:0] count;
    pred_entry_t        head;
    pred_entry_t        push_entry;
    logic               head_valid, full;
    logic               resolve_ok, mis, flush, push_ok;

    always_comb begin
        head_valid = (count != '0);
        full       = (count == COUNT_W'(DEPTH));
        resolve_ok = bus.en & bus.resolve & head_valid;
        mis        = (bus.resolve_next_pc != head.pred_pc);
        flush      = resolve_ok & mis;
        // A push alongside a mispredicting resolve is wrong-path and dropped
        push_ok    = bus.en & bus.push & (~full | resolve_ok) & ~flush;
        push_entry = '{pc: bus.push_pc, instr: bus.push_instr, pred_pc: bus.push_pred_pc};
    end

    pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr       (push_ok),
        .wr_entry (push_entry),
        .rd       (resolve_ok),
        .flush    (flush),
        .head     (head),
        .count    (count)
    );

    logic        miss_q, miss_d;
    logic [31:0] last_pc_q, last_pc_d;
    logic [31:0] last_instr_q, last_instr_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    always_comb begin
        miss_d        = miss_q;
        last_pc_d     = last_pc_q;
        last_instr_d  = last_instr_q;
        redirect_d    = redirect_q;
        redirect_pc_d = redirect_pc_q;
        // With en low everything holds, which stretches a redirect pulse
        if (bus.en) begin
            redirect_d = 1'b0;
            if (resolve_ok) begin
                miss_d       = mis;
                last_pc_d    = head.pc;
                last_instr_d = head.instr;
                if (mis) begin
                    redirect_d    = 1'b1;
                    redirect_pc_d = bus.resolve_next_pc;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss_q        <= 1'b0;
            last_pc_q     <= '0;
            last_instr_q  <= NOP_INSTR;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            miss_q        <= miss_d;
            last_pc_q     <= last_pc_d;
            last_instr_q  <= last_instr_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

`ifdef PRED_CHECK_STATS_EN
    logic        head_is_br;
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_misses_q, stat_misses_d;

    always_comb begin
        head_is_br      = has_trait(head.instr[6:0], T_BR);
        stat_branches_d = stat_branches_q;
        stat_misses_d   = stat_misses_q;
        if (resolve_ok && head_is_br) begin
            stat_branches_d = stat_branches_q + 32'd1;
            if (mis) stat_misses_d = stat_misses_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_branches_q <= '0;
            stat_misses_q   <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_misses_q   <= stat_misses_d;
        end
    end

    assign bus.stat_branches = stat_branches_q;
    assign bus.stat_misses   = stat_misses_q;
`endif

    assign bus.full        = full;
    assign bus.head_valid  = head_valid;
    assign bus.head_pc     = head.pc;
    assign bus.head_instr  = head.instr;
    assign bus.miss        = miss_q;
    assign bus.last_pc     = last_pc_q;
    assign bus.last_instr  = last_instr_q;
    assign bus.redirect    = redirect_q;
    assign bus.redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_pred_check_queue.sv
// Scoreboard bench for pred_check_queue: a queue-based reference model
// predicts the post-edge outputs of every cycle; a monitor compares them.
module tb_pred_check_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pred;
    } m_ent_t;

    typedef struct {
        logic        full;
        logic        hv;
        logic [31:0] hpc;
        logic [31:0] hinstr;
        logic        miss;
        logic [31:0] lpc;
        logic [31:0] linstr;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] sb;
        logic [31:0] sm;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pred_check_queue_if bus();

    pred_check_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    m_ent_t      mq[$];
    exp_t        exp_q[$];
    logic        m_miss, m_redir;
    logic [31:0] m_lpc, m_linstr, m_rpc, m_sb, m_sm;
    int          n_vec = 0;
    int          n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic bit is_br(input logic [31:0] i);
        return i[6:0] == 7'h63;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_miss = 0; m_redir = 0;
        m_lpc = 0; m_linstr = 0; m_rpc = 0; m_sb = 0; m_sm = 0;
    endfunction

    function automatic logic [31:0] head_pred();
        return (mq.size() != 0) ? mq[0].pred : 32'h0;
    endfunction

    task automatic idle_inputs();
        bus.en = 1'b1; bus.push = 1'b0; bus.resolve = 1'b0;
        bus.push_pc = '0; bus.push_instr = '0; bus.push_pred_pc = '0;
        bus.resolve_next_pc = '0;
    endtask

    // One clock of stimulus; the model advances by the same rules and the
    // expected post-edge state goes to the scoreboard.
    task automatic cycle(input bit en, input bit push, input logic [31:0] pc,
                         input logic [31:0] instr, input logic [31:0] pred,
                         input bit res, input logic [31:0] rnpc);
        bit hv, fl, rok, mis, pok;
        m_ent_t h;
        exp_t e;
        @(negedge clk);
        bus.en = en; bus.push = push; bus.push_pc = pc; bus.push_instr = instr;
        bus.push_pred_pc = pred; bus.resolve = res; bus.resolve_next_pc = rnpc;
        hv  = mq.size() != 0;
        fl  = mq.size() == DEPTH;
        rok = en && res && hv;
        mis = 0;
        h   = '{pc: 0, instr: 0, pred: 0};
        if (rok) begin
            h = mq[0];
            mis = (rnpc != h.pred);
        end
        pok = en && push && (!fl || rok) && !(rok && mis);
        if (en) m_redir = 0;
        if (rok) begin
            mq.delete(0);
            m_lpc = h.pc; m_linstr = h.instr; m_miss = mis;
            if (is_br(h.instr)) begin
                m_sb++;
                if (mis) m_sm++;
            end
            if (mis) begin
                m_redir = 1; m_rpc = rnpc;
                mq.delete();
            end
        end
        if (pok) mq.push_back('{pc: pc, instr: instr, pred: pred});
        e.full   = (mq.size() == DEPTH);
        e.hv     = (mq.size() != 0);
        e.hpc    = e.hv ? mq[0].pc : 32'h0;
        e.hinstr = e.hv ? mq[0].instr : 32'h0;
        e.miss = m_miss; e.lpc = m_lpc; e.linstr = m_linstr;
        e.redir = m_redir; e.rpc = m_rpc; e.sb = m_sb; e.sm = m_sm;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        cycle(1, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic reset_check();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_head_valid", bus.head_valid, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_miss", bus.miss, 0);
        chk("rst_redirect", bus.redirect, 0);
        chk("rst_redirect_pc", bus.redirect_pc, 0);
        chk("rst_last_pc", bus.last_pc, 0);
        chk("rst_last_instr", bus.last_instr, 0);
`ifdef PRED_CHECK_STATS_EN
        chk("rst_stat_branches", bus.stat_branches, 0);
        chk("rst_stat_misses", bus.stat_misses, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Monitor: compares one scoreboard record after each active edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("full", bus.full, e.full);
                chk("head_valid", bus.head_valid, e.hv);
                if (e.hv) begin
                    chk("head_pc", bus.head_pc, e.hpc);
                    chk("head_instr", bus.head_instr, e.hinstr);
                end
                chk("miss", bus.miss, e.miss);
                chk("last_pc", bus.last_pc, e.lpc);
                chk("last_instr", bus.last_instr, e.linstr);
                chk("redirect", bus.redirect, e.redir);
                chk("redirect_pc", bus.redirect_pc, e.rpc);
`ifdef PRED_CHECK_STATS_EN
                chk("stat_branches", bus.stat_branches, e.sb);
                chk("stat_misses", bus.stat_misses, e.sm);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc, instr, rnd;
        idle_inputs();
        reset = 1'b1;
        model_reset();
        reset_check();

        // Correct prediction on a single entry
        cycle(1, 1, 32'h100, 32'h0000_0013, 32'h104, 0, 0);
        cycle(1, 0, 0, 0, 0, 1, 32'h104);
        idle();

        // Mispredict flushes the younger entry
        cycle(1, 1, 32'h200, 32'h0000_0013, 32'h204, 0, 0);
        cycle(1, 1, 32'h204, 32'h0000_0013, 32'h208, 0, 0);
        cycle(1, 0, 0, 0, 0, 1, 32'h300);
        idle();
        idle();

        // Fill, then push+correct resolve across pointer wrap, then drain
        for (int k = 0; k < DEPTH; k++)
            cycle(1, 1, 32'h1000 + 32'(k * 4), 32'h0000_0013, 32'h1004 + 32'(k * 4), 0, 0);
        cycle(1, 1, 32'h2000, 32'h0000_0013, 32'h2004, 0, 0);
        for (int k = 0; k < 8; k++)
            cycle(1, 1, 32'h3000 + 32'(k * 4), 32'h0000_0013, 32'h3004 + 32'(k * 4), 1, head_pred());
        for (int k = 0; k < DEPTH; k++)
            cycle(1, 0, 0, 0, 0, 1, head_pred());

        // Resolve on empty queue is ignored
        cycle(1, 0, 0, 0, 0, 1, 32'hdead_beef);
        idle();

        // Redirect stretched across en=0
        cycle(1, 1, 32'h400, 32'h0000_0013, 32'h404, 0, 0);
        cycle(1, 0, 0, 0, 0, 1, 32'h500);
        cycle(0, 1, 32'h600, 32'h0000_0013, 32'h604, 1, 32'h700);
        cycle(0, 0, 0, 0, 0, 0, 0);
        idle();
        idle();

        // Two branch resolves, one missing, then reset with 3 queued and miss=1
        cycle(1, 1, 32'h800, 32'h0000_0063, 32'h804, 0, 0);
        cycle(1, 1, 32'h804, 32'h0040_0063, 32'h900, 0, 0);
        cycle(1, 0, 0, 0, 0, 1, 32'h804);
        cycle(1, 0, 0, 0, 0, 1, 32'h808);
        for (int k = 0; k < 3; k++)
            cycle(1, 1, 32'ha00 + 32'(k * 4), 32'h0000_0013, 32'ha04 + 32'(k * 4), 0, 0);
        idle();
        @(negedge clk);
`ifdef PRED_CHECK_STATS_EN
        chk("stats_branches_2", bus.stat_branches, 2);
        chk("stats_misses_1", bus.stat_misses, 1);
`endif
        chk("pre_rst_miss", bus.miss, 1);
        reset_check();

        // Randomized traffic with one mid-stream reset
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) reset_check();
            pc    = $urandom;
            rnd   = $urandom;
            instr = ($urandom_range(2) == 0) ? {rnd[31:7], 7'h63} : rnd;
            cycle(($urandom_range(7) != 0), ($urandom_range(2) != 0), pc, instr, pc + 32'd4,
                  $urandom_range(1) == 1,
                  ($urandom_range(4) != 0 && mq.size() != 0) ? head_pred() : $urandom);
        end
        idle();

        for (int k = 0; k < 5 && exp_q.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pred_check_queue.md
Name: pred_check_queue

Overview:
- Sits between fetch (the frontend predictor producing pred_pc) and execute.
- Buffers each fetched instruction's PC, instruction word and predicted next PC in program order.
- When execute resolves the oldest entry's real next PC, the block compares it with the prediction and produces the registered miss/last_pc/last_instr feedback the predictor trains on, plus a redirect and flush on mispredict.

Parameters:
- DEPTH, 4, number of in-flight entries; power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- en  in  1  global pipeline enable; when 0, no state changes (outputs hold)
- push  in  1  fetch enqueues an entry this cycle
- push_pc  in  32  PC of the fetched instruction
- push_instr  in  32  fetched instruction word
- push_pred_pc  in  32  predicted next PC for that instruction
- full  out  1  no free entries; fetch must stall
- resolve  in  1  execute retires the oldest entry this cycle
- resolve_next_pc  in  32  actual next PC of the oldest entry
- head_valid  out  1  queue non-empty; oldest entry is available to execute
- head_pc  out  32  PC of the oldest entry (combinational from head)
- head_instr  out  32  instruction of the oldest entry (combinational)
- miss  out  1  registered; last resolved prediction was wrong
- last_pc  out  32  registered PC of the last resolved entry
- last_instr  out  32  registered instruction of the last resolved entry
- redirect  out  1  registered one-cycle pulse on mispredict
- redirect_pc  out  32  registered correct PC; valid while redirect=1

Behaviour:
- Reset (async): rd_ptr=wr_ptr=0, count=0, miss=0, redirect=0, redirect_pc=0, last_pc=0, last_instr=0 (decodes as NOP, so the predictor ignores it). Entry storage is not reset.
- State per entry: pc, instr, pred_pc. Circular buffer with PTR_W-bit pointers that wrap modulo DEPTH. count is PTR_W+1 bits.
- full = (count==DEPTH). head_valid = (count!=0).
- Push accepted iff en & push & (~full | resolve_ok). A push into a full queue on the same cycle as a pop is legal.
- resolve_ok = en & resolve & head_valid. A resolve on an empty queue is ignored: no pop, no output update.
- On resolve_ok the block performs the following, all on the next edge:
  - mis = (resolve_next_pc != head pred_pc)
  - last_pc <= head pc; last_instr <= head instr; miss <= mis
  - rd_ptr advances by 1
  - if mis: redirect <= 1, redirect_pc <= resolve_next_pc, and all younger entries are flushed (rd_ptr=wr_ptr=the popped rd_ptr+1, count=0).
  - Any push in the same cycle as a mispredicting resolve is discarded; it is wrong-path.
- If no resolve_ok: miss holds its value; last_pc/last_instr hold; redirect <= 0.
- Latency: resolve to miss/redirect visible is 1 cycle. Push to head visible is 1 cycle when the queue was empty.
- en=0: pointers, count, storage and all registered outputs hold, including redirect, so a pulse is stretched across the stall. The predictor samples miss under the same en.
- Simultaneous push and non-miss resolve: count unchanged, both pointers advance.
- Reset asserted mid-operation: immediate clear as above; in-flight entries are lost.

Optional Feature:
- Macro: PRED_CHECK_STATS_EN.
- When defined:
  - Adds outputs stat_branches[31:0] and stat_misses[31:0].
  - On resolve_ok where head instr decodes as a conditional branch, stat_branches increments. If that resolve also mispredicts, stat_misses increments.
  - Both counters reset to 0, wrap at 2^32 and respect en.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pred_pkg holds:
  - typedef pred_entry_t {pc, instr, pred_pc}
  - constant NOP_INSTR=32'h0
- The conditional-branch decode for stats reuses the existing instruction-traits decoder and its T_BR bit.
- One sub-module: pred_fifo, the circular storage with pointers, count and flush. pred_check_queue wraps it with compare/redirect logic.

Test Plan:
- Push PC 0x100/pred 0x104, resolve with 0x104 -> next cycle miss=0, last_pc=0x100, redirect=0, head_valid=0.
- Push 0x200 (pred 0x204) and 0x204 (pred 0x208); resolve 0x200 with actual 0x300 -> miss=1, redirect=1, redirect_pc=0x300, queue empty (0x204 flushed), redirect=0 the following cycle.
- Fill DEPTH=4 entries -> full=1. Same cycle push+resolve (correct) -> accepted, full stays 1, FIFO order preserved across pointer wrap over 8 pushes.
- Resolve with queue empty -> miss, last_pc, redirect unchanged.
- Mispredict resolve with en=0 during the following cycle -> redirect stays 1 until en=1 for one edge.
- Assert reset with 3 entries queued and miss=1 -> immediately count=0, miss=0, redirect=0, last_instr=0. With PRED_CHECK_STATS_EN, 2 branch resolves with 1 miss -> stat_branches=2, stat_misses=1.
